conv_kernel_driver: RTL and testbench
=====================================

# conv_kernel_driver

Initiator for the `ConvKernel` start/finish handshake. On a `go` pulse, the block walks every 2x2 window (stride 1, no padding) of a multi-channel feature map held in a synchronous-read memory. For each window it packs the 2x2xC operand vector, pulses `start` to the kernel, waits for `finish`, and writes the captured `result` to an output memory. It sits between the feature-map buffer and one `ConvKernel` instance. Weight and bias vectors are not handled here; they are wired straight from the filter store to the kernel.

## Interface
- `BITWIDTH`, 32, word width (IEEE-754 single, opaque to this block)
- `DATACHANNEL`, 10, input channels C
- `IMG_W`, 8, feature-map width (>=2)
- `IMG_H`, 8, feature-map height (>=2)
- `ADDR_WIDTH`, 12, read/write address width
- `TIMEOUT`, 64, max cycles spent in WAIT (used only with the macro below)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `go`  in  1  start a full-map pass (sampled in IDLE only)
- `busy`  out  1  high from the cycle after accepted `go` until DONE
- `done`  out  1  one-cycle pulse at end of pass
- `err`  out  1  sticky timeout flag; cleared by accepted `go` or `rst`
- `rd_en`  out  1  feature-map read strobe
- `rd_addr`  out  ADDR_WIDTH  feature-map address = (c*IMG_H + y)*IMG_W + x
- `rd_data`  in  BITWIDTH  valid exactly one cycle after `rd_en`
- `kern_data`  out  BITWIDTH*4*C  packed window; element i = c*4 + ky*2 + kx at bits [i*BITWIDTH +: BITWIDTH]
- `kern_start`  out  1  one-cycle start pulse to kernel
- `kern_finish`  in  1  kernel completion
- `kern_result`  in  BITWIDTH  kernel output, valid when `kern_finish`=1
- `wr_en`  out  1  output-memory write strobe
- `wr_addr`  out  ADDR_WIDTH  = oy*(IMG_W-1) + ox
- `wr_data`  out  BITWIDTH  result word

## Operation
- States: IDLE, FETCH, FIRE, WAIT, WRITE, DONE.
- IDLE: if `go`=1, go to FETCH; set window (ox,oy)=(0,0) and clear `err`.
- FETCH: issue 4C reads on consecutive cycles in element order i=0..4C-1. Capture `rd_data` into slot i one cycle later. FETCH lasts 4C+1 cycles; in the last cycle there is no read, only the final capture.
- FIRE: `kern_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: when `kern_finish`=1, latch `kern_result` and go to WRITE. `kern_finish` is ignored in every other state, including FIRE.
- WRITE: `wr_en`=1 for one cycle with the latched result. Then advance ox; when ox wraps from IMG_W-2 to 0, increment oy. After window (IMG_W-2, IMG_H-2), go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `kern_data` holds stable from the end of FETCH until the next FETCH begins overwriting it.
- `go` while busy is ignored.
- No arithmetic is performed on data words; only the address and counter arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset values: `busy`, `done`, `err`, `rd_en`, `kern_start`, `wr_en` = 0; `rd_addr`, `wr_addr`, `wr_data`, `kern_data` = 0; state = IDLE.
- Per-window cycle count = (4C+1) + 1 + L + 1, where L is the number of WAIT cycles up to and including the cycle `kern_finish` is seen.
- Total pass length = (IMG_W-1)*(IMG_H-1) windows, plus 1 cycle for DONE.
- `rst` mid-pass: the block returns to IDLE on the next edge. Any in-flight kernel result is discarded, and a later stray `kern_finish` is ignored.
- `kern_finish` and `rst` in the same cycle: reset wins, and no write occurs.

## Configuration
- `CONV_DRIVER_TIMEOUT_EN` defined: a WAIT cycle counter is added.
  - If TIMEOUT cycles elapse without `kern_finish`, the latched result becomes 32'h7FC00000 (quiet NaN) and `err` is set.
  - The block then proceeds to WRITE and continues the pass.
- Not defined: WAIT is unbounded, `err` is tied to 0, and `TIMEOUT` is unused.

## Test plan
- C=2, IMG 3x3, `rd_data`=address, kernel model with finish 5 cycles after start returning 32'h0000_00A0+window index -> exactly 4 writes to addresses 0,1,2,3 with data A0,A1,A2,A3; `done` pulses once; `busy` falls the same cycle.
- Same setup, check first `kern_data` -> element i=0..7 equals addresses {0,1,3,4,9,10,12,13}; `kern_start` is high exactly once per window.
- `kern_finish` held high during FIRE and IDLE -> no early capture and no spurious `wr_en`.
- `rst` asserted during WAIT of window 2 -> all outputs 0 next cycle; a subsequent `go` restarts at window (0,0).
- `go` pulsed again while busy -> ignored; write count stays 4.
- With `CONV_DRIVER_TIMEOUT_EN` and TIMEOUT=16, kernel never finishes -> 4 writes of 32'h7FC00000, `err`=1 until next `go`.

Source files
------------

// File: rtl/conv_kernel_driver.sv
// Walks every 2x2 window of a C-channel feature map, feeds one ConvKernel, stores each result.
// Optional feature: define CONV_DRIVER_TIMEOUT_EN to bound WAIT by TIMEOUT cycles (writes quiet NaN, sets err).
module conv_kernel_driver #(
  parameter int BITWIDTH    = 32,
  parameter int DATACHANNEL = 10,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              go,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  input  logic [BITWIDTH-1:0]               rd_data,
  output logic [BITWIDTH*4*DATACHANNEL-1:0] kern_data,
  output logic                              kern_start,
  input  logic                              kern_finish,
  input  logic [BITWIDTH-1:0]               kern_result,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [BITWIDTH-1:0]               wr_data
);

  localparam int numElem = 4 * DATACHANNEL;
  localparam int cntW    = $clog2(numElem + 1);

  localparam logic [cntW-1:0]       lastFetch = cntW'(numElem);
  localparam logic [cntW-1:0]       cntOne    = cntW'(1);
  localparam logic [ADDR_WIDTH-1:0] addrOne   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] imgWA     = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] imgHA     = ADDR_WIDTH'(IMG_H);
  localparam logic [ADDR_WIDTH-1:0] outWA     = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [ADDR_WIDTH-1:0] lastOx    = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] lastOy    = ADDR_WIDTH'(IMG_H - 2);
  localparam logic [BITWIDTH-1:0]   nanWord   = BITWIDTH'(32'h7FC0_0000);

  typedef enum logic [2:0] {IDLE, FETCH, FIRE, WAIT, WRITE, DONE} stateT;

  stateT                              state;
  stateT                              nextState;
  logic [cntW-1:0]                    fetchCnt;
  logic [cntW-1:0]                    captIdx;
  logic [ADDR_WIDTH-1:0]              ox;
  logic [ADDR_WIDTH-1:0]              oy;
  logic [ADDR_WIDTH-1:0]              chanIdx;
  logic [ADDR_WIDTH-1:0]              kyOff;
  logic [ADDR_WIDTH-1:0]              kxOff;
  logic [ADDR_WIDTH-1:0]              rdAddrCalc;
  logic [BITWIDTH*4*DATACHANNEL-1:0]  kernBuf;
  logic [BITWIDTH-1:0]                resultReg;
  logic                               timedOut;
  logic                               lastWindow;

  // Fetch counter doubles as element index: i = c*4 + ky*2 + kx.
  assign chanIdx    = ADDR_WIDTH'(fetchCnt >> 2);
  assign kyOff      = ADDR_WIDTH'(fetchCnt[1]);
  assign kxOff      = ADDR_WIDTH'(fetchCnt[0]);
  assign rdAddrCalc = (chanIdx * imgHA + oy + kyOff) * imgWA + ox + kxOff;
  assign captIdx    = fetchCnt - cntOne;
  assign lastWindow = (ox == lastOx) && (oy == lastOy);
  assign kern_data  = kernBuf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (go) nextState = FETCH;
      FETCH:   if (fetchCnt == lastFetch) nextState = FIRE;
      FIRE:    nextState = WAIT;
      WAIT:    if (kern_finish || timedOut) nextState = WRITE;
      WRITE:   nextState = lastWindow ? DONE : FETCH;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = state inside {FETCH, FIRE, WAIT, WRITE};
    done       = (state == DONE);
    rd_en      = (state == FETCH) && (fetchCnt != lastFetch);
    rd_addr    = rd_en ? rdAddrCalc : '0;
    kern_start = (state == FIRE);
    wr_en      = (state == WRITE);
    wr_addr    = wr_en ? (oy * outWA + ox) : '0;
    wr_data    = wr_en ? resultReg : '0;
  end

  // Read data lags the strobe by one cycle, so slot i is filled while fetchCnt = i+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCnt  <= '0;
      ox        <= '0;
      oy        <= '0;
      kernBuf   <= '0;
      resultReg <= '0;
    end else begin
      fetchCnt <= (state == FETCH) ? fetchCnt + cntOne : '0;
      if (state == IDLE && go) begin
        ox <= '0;
        oy <= '0;
      end
      if (state == FETCH && fetchCnt != '0) begin
        for (int i = 0; i < numElem; i++) begin
          if (captIdx == cntW'(i)) begin
            kernBuf[i*BITWIDTH +: BITWIDTH] <= rd_data;
          end
        end
      end
      if (state == WAIT) begin
        if (kern_finish) begin
          resultReg <= kern_result;
        end else if (timedOut) begin
          resultReg <= nanWord;
        end
      end
      if (state == WRITE) begin
        if (ox == lastOx) begin
          ox <= '0;
          oy <= oy + addrOne;
        end else begin
          ox <= ox + addrOne;
        end
      end
    end
  end

`ifdef CONV_DRIVER_TIMEOUT_EN
  localparam int waitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [waitW-1:0] waitCnt;
  logic             errReg;

  assign timedOut = (state == WAIT) && !kern_finish && (waitCnt == waitW'(TIMEOUT - 1));
  assign err      = errReg;

  // err is sticky across the rest of the pass and only an accepted go or reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
      errReg  <= 1'b0;
    end else begin
      waitCnt <= (state == WAIT) ? waitCnt + waitW'(1) : '0;
      if (state == IDLE && go) begin
        errReg <= 1'b0;
      end else if (timedOut) begin
        errReg <= 1'b1;
      end
    end
  end
`else
  logic unusedTimeout;

  assign unusedTimeout = (TIMEOUT != 0);
  assign timedOut      = 1'b0;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_conv_kernel_driver.sv
// Directed bench for conv_kernel_driver on a 3x3, 2-channel map with a model memory and kernel.
// Build with CONV_DRIVER_TIMEOUT_EN defined to also exercise the WAIT timeout path.
module tb_conv_kernel_driver;

  localparam int BW         = 32;
  localparam int C          = 2;
  localparam int W          = 3;
  localparam int H          = 3;
  localparam int AW         = 12;
  localparam int TMO        = 16;
  localparam int NELEM      = 4 * C;
  localparam int KW         = BW * NELEM;
  localparam int NWIN       = (W - 1) * (H - 1);
  localparam int KERN_DELAY = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wrT;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_data;
  logic [KW-1:0] kern_data;
  logic          kern_start;
  logic          kern_finish = 1'b0;
  logic [BW-1:0] kern_result = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data;

  logic          forceFinish;
  logic          neverFinish;
  int            kernCnt = 0;
  int            winIdx = 0;

  int            vecCount = 0;
  int            missCount = 0;
  wrT            expQ[$];
  logic [AW-1:0] logAddr[$];
  logic [BW-1:0] logData[$];
  logic [KW-1:0] firstKernData;
  int            monWin;
  int            startsSinceWrite;
  int            startCount;
  int            doneCount = 0;
  int            busyCycles;

  conv_kernel_driver #(
    .BITWIDTH(BW), .DATACHANNEL(C), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .kern_data(kern_data),
    .kern_start(kern_start), .kern_finish(kern_finish), .kern_result(kern_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Feature map whose word at each address is the address itself; garbage when not read.
  always @(posedge clk) rd_data <= rd_en ? BW'(rd_addr) : 32'hBAD0_BAD0;

  // Kernel finishes KERN_DELAY cycles after start with result A0 + window index of the pass.
  always @(posedge clk) begin
    if (rst || (go && !busy)) begin
      winIdx      <= 0;
      kern_result <= 32'hDEAD_BEEF;
    end else if (kern_start) begin
      kern_result <= 32'hA0 + winIdx;
      winIdx      <= winIdx + 1;
    end
    if (kern_start) kernCnt <= KERN_DELAY - 1;
    else if (kernCnt != 0) kernCnt <= kernCnt - 1;
    kern_finish <= forceFinish || (!neverFinish && !kern_start && kernCnt == 1);
  end

  task automatic checkOutput(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected operand vector for window w straight from the address formula.
  function automatic logic [KW-1:0] windowVector(input int w);
    logic [KW-1:0] v = '0;
    int ox = w % (W - 1);
    int oy = w / (W - 1);
    for (int c = 0; c < C; c++)
      for (int ky = 0; ky < 2; ky++)
        for (int kx = 0; kx < 2; kx++)
          v[(c*4 + ky*2 + kx)*BW +: BW] = BW'((c*H + oy + ky)*W + ox + kx);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic goV, input logic rstV, input logic ffV, input int cycles);
    go = goV;
    rst = rstV;
    forceFinish = ffV;
    repeat (cycles) tick();
  endtask

  task automatic clearModel();
    expQ.delete();
    logAddr.delete();
    logData.delete();
    monWin = 0;
    startsSinceWrite = 0;
    startCount = 0;
    busyCycles = 0;
  endtask

  task automatic loadModel(input logic useFixed, input logic [BW-1:0] fixedData);
    clearModel();
    for (int w = 0; w < NWIN; w++)
      expQ.push_back('{addr: AW'(w), data: useFixed ? fixedData : BW'(32'hA0 + w)});
  endtask

  task automatic monitorLoop();
    wrT e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busyCycles++;
      if (kern_start === 1'b1) begin
        checkOutput("one_start_per_window", KW'(startsSinceWrite), '0);
        checkOutput("kern_data", kern_data, windowVector(monWin));
        if (monWin == 0) firstKernData = kern_data;
        monWin++;
        startsSinceWrite++;
        startCount++;
      end
      if (wr_en === 1'b1) begin
        logAddr.push_back(wr_addr);
        logData.push_back(wr_data);
        startsSinceWrite = 0;
        checkOutput("wr_en_expected", KW'(wr_en), KW'(expQ.size() != 0));
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("wr_addr", KW'(wr_addr), KW'(e.addr));
          checkOutput("wr_data", KW'(wr_data), KW'(e.data));
        end
      end
      if (done === 1'b1) begin
        doneCount++;
        checkOutput("busy_at_done", KW'(busy), '0);
        checkOutput("writes_pending_at_done", KW'(expQ.size()), '0);
      end
    end
  endtask

  task automatic waitDone(input int maxCycles);
    int startDone = doneCount;
    int n = 0;
    while (doneCount == startDone && n < maxCycles) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checkOutput("done_pulse_count", KW'(doneCount - startDone), KW'(1));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, KW'(busy), '0);
    checkOutput({tag, "_done"}, KW'(done), '0);
    checkOutput({tag, "_err"}, KW'(err), '0);
    checkOutput({tag, "_rd_en"}, KW'(rd_en), '0);
    checkOutput({tag, "_rd_addr"}, KW'(rd_addr), '0);
    checkOutput({tag, "_kern_start"}, KW'(kern_start), '0);
    checkOutput({tag, "_wr_en"}, KW'(wr_en), '0);
    checkOutput({tag, "_wr_addr"}, KW'(wr_addr), '0);
    checkOutput({tag, "_wr_data"}, KW'(wr_data), '0);
    checkOutput({tag, "_kern_data"}, kern_data, '0);
  endtask

  initial begin
    int litAddr[4] = '{0, 1, 2, 3};
    int litData[4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    int litElem[8] = '{0, 1, 3, 4, 9, 10, 12, 13};
    logic [KW-1:0] litVec = '0;
    int n;

    for (int i = 0; i < 8; i++) litVec[i*BW +: BW] = BW'(litElem[i]);
    rst = 1'b1;
    go = 1'b0;
    forceFinish = 1'b0;
    neverFinish = 1'b0;
    clearModel();
    fork
      monitorLoop();
    join_none

    repeat (3) tick();
    checkAllZero("reset");
    applyStimulus(0, 0, 0, 2);
    checkAllZero("idle");

    // Normal pass, with a second go while busy that must be ignored.
    loadModel(1'b0, '0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("busy_after_go", KW'(busy), KW'(1));
    checkOutput("first_rd_en", KW'(rd_en), KW'(1));
    checkOutput("first_rd_addr", KW'(rd_addr), '0);
    applyStimulus(0, 0, 0, 6);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    waitDone(300);
    checkOutput("p1_write_count", KW'(logAddr.size()), KW'(4));
    for (int i = 0; i < 4 && i < logAddr.size(); i++) begin
      checkOutput($sformatf("p1_lit_addr%0d", i), KW'(logAddr[i]), KW'(litAddr[i]));
      checkOutput($sformatf("p1_lit_data%0d", i), KW'(logData[i]), KW'(litData[i]));
    end
    checkOutput("p1_lit_first_kern_data", firstKernData, litVec);
    checkOutput("p1_start_count", KW'(startCount), KW'(4));
    checkOutput("p1_busy_cycles", KW'(busyCycles), KW'(64));
    checkOutput("p1_err", KW'(err), '0);

    // kern_finish stuck high through IDLE and FIRE must not cause early capture or writes.
    clearModel();
    applyStimulus(0, 0, 1, 4);
    checkOutput("idle_finish_writes", KW'(logAddr.size()), '0);
    loadModel(1'b0, '0);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(0, 0, 1, 1);
    waitDone(300);
    checkOutput("p2_busy_cycles", KW'(busyCycles), KW'(48));
    applyStimulus(0, 0, 0, 2);

    // Reset lands in the same cycle as window 2's finish: no write, everything cleared.
    loadModel(1'b0, '0);
    applyStimulus(1, 0, 0, 1);
    go = 1'b0;
    n = 0;
    while (!(monWin == 3 && kern_finish === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("reached_window2_finish", KW'(monWin), KW'(3));
    expQ.delete();
    applyStimulus(0, 1, 0, 1);
    checkAllZero("midrst");
    applyStimulus(0, 0, 1, 3);
    applyStimulus(0, 0, 0, 4);
    checkOutput("midrst_write_count", KW'(logAddr.size()), KW'(2));

    // Fresh pass after reset restarts at window (0,0).
    loadModel(1'b0, '0);
    applyStimulus(1, 0, 0, 1);
    go = 1'b0;
    waitDone(300);
    checkOutput("p4_first_kern_data", firstKernData, litVec);
    checkOutput("p4_write_count", KW'(logAddr.size()), KW'(4));
    if (logAddr.size() > 0) checkOutput("p4_first_addr", KW'(logAddr[0]), '0);

`ifdef CONV_DRIVER_TIMEOUT_EN
    // Kernel never answers: every window times out into a quiet NaN and err sticks.
    neverFinish = 1'b1;
    loadModel(1'b1, 32'h7FC0_0000);
    applyStimulus(1, 0, 0, 1);
    go = 1'b0;
    waitDone(600);
    checkOutput("tmo_write_count", KW'(logAddr.size()), KW'(4));
    if (logData.size() > 0) checkOutput("tmo_lit_nan", KW'(logData[0]), KW'(32'h7FC0_0000));
    checkOutput("tmo_busy_cycles", KW'(busyCycles), KW'(108));
    checkOutput("tmo_err_after_done", KW'(err), KW'(1));
    applyStimulus(0, 0, 0, 4);
    checkOutput("tmo_err_sticky", KW'(err), KW'(1));
    neverFinish = 1'b0;
    loadModel(1'b0, '0);
    applyStimulus(1, 0, 0, 1);
    go = 1'b0;
    checkOutput("tmo_err_cleared_by_go", KW'(err), '0);
    waitDone(300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
